// File: rtl/pixel_writer.sv
// pixel_writer
//   Captures finished julia workers reported by the search stage into a small
//   FIFO, releases each captured worker with a one-cycle free pulse, drains the
//   FIFO to the frame buffer through an Avalon-MM write master, and counts
//   accepted writes to flag the end of each frame.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   found, mask         search has a selected worker / its one-hot select
//   sel_data            pixel word of the selected worker
//   sel_address         pixel index (word address) of the selected worker
//   free                one-cycle one-hot release back to the captured worker
//   avm_*               Avalon-MM write master (byte addressed)
//   fifo_level          current FIFO occupancy (0..DEPTH)
//   frame_done          one-cycle pulse on the last pixel of a frame
//   pixel_count         accepted writes in the current frame
//
// Capture FSM
//   state   | meaning
//   IDLE    | ready to capture a reported worker when the FIFO has room
//   HOLD    | worker just captured; wait for its done flag to drop
module pixel_writer #(
  parameter int                NUM_JULIA    = 16,
  parameter int                DEPTH        = 8,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE    = '0,
  parameter int                FRAME_PIXELS = 307200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     found,
  input  logic [31:0]              sel_data,
  input  logic [31:0]              sel_address,
  input  logic [NUM_JULIA-1:0]     mask,
  output logic [NUM_JULIA-1:0]     free,
  output logic [ADDR_W-1:0]        avm_address,
  output logic                     avm_write,
  output logic [31:0]              avm_writedata,
  output logic [3:0]               avm_byteenable,
  input  logic                     avm_waitrequest,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_done,
  output logic [31:0]              pixel_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  // FIFO entry: {word address, pixel data}
  logic [63:0]          mem_q [DEPTH];
  logic [63:0]          mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;

  state_t               state_q, state_d;
  logic [NUM_JULIA-1:0] held_mask_q, held_mask_d;
  logic [NUM_JULIA-1:0] free_q, free_d;

  logic                 write_q, write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;

  logic [31:0]          pix_cnt_q, pix_cnt_d;
  logic                 frame_done_q, frame_done_d;

  logic                 full;
  logic                 push;
  logic                 accept;
  logic [PTR_W-1:0]     rd_ptr_nxt;
  logic [31:0]          pix_cnt_inc;

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [31:0] word);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'({word, 2'b00});
    return ADDR_BASE + off;
  endfunction

  // Full comes from the registered level, so a pop in the same cycle never
  // opens room for a push.
  assign full       = (level_q == LVL_W'(DEPTH));
  assign push       = (state_q == ST_IDLE) && found && !full;
  assign accept     = write_q && !avm_waitrequest;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign pix_cnt_inc = pix_cnt_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    held_mask_d = held_mask_q;
    free_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          free_d      = mask;
          held_mask_d = mask;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The worker's done flag takes a cycle or two to fall; stay here
        // until search moves on so the same worker is not captured twice.
        if (!found || (mask != held_mask_q)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {sel_address, sel_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (accept) begin
      rd_ptr_d = rd_ptr_nxt;
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(accept);
  end

  // The head entry stays in the FIFO while it is presented; it is popped
  // only when the slave accepts it.
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (!write_q) begin
      if (level_q != '0) begin
        write_d = 1'b1;
        addr_d  = byte_addr(mem_q[rd_ptr_q][63:32]);
        wdata_d = mem_q[rd_ptr_q][31:0];
        be_d    = 4'hF;
      end
    end else if (accept) begin
      if (level_q > LVL_W'(1)) begin
        addr_d  = byte_addr(mem_q[rd_ptr_nxt][63:32]);
        wdata_d = mem_q[rd_ptr_nxt][31:0];
      end else begin
        write_d = 1'b0;
        be_d    = 4'h0;
      end
    end
  end

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (pix_cnt_inc == 32'(FRAME_PIXELS)) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= ST_IDLE;
      held_mask_q  <= '0;
      free_q       <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      held_mask_q  <= held_mask_d;
      free_q       <= free_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign free           = free_q;
  assign avm_address    = addr_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign fifo_level     = level_q;
  assign frame_done     = frame_done_q;
  assign pixel_count    = pix_cnt_q;

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;

  localparam int NJ    = 16;
  localparam int DEPTH = 8;
  localparam int FP    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        found;
  logic [31:0] sel_data;
  logic [31:0] sel_address;
  logic [NJ-1:0] mask;
  logic [NJ-1:0] free;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [3:0]  fifo_level;
  logic        frame_done;
  logic [31:0] pixel_count;

  int checks   = 0;
  int failures = 0;

  logic [63:0] wr_log[$];
  logic [15:0] free_log[$];
  int          fd_cnt = 0;
  int          fd_at  = 0;
  logic [31:0] pc_at_fd = '0;

  pixel_writer #(
    .NUM_JULIA   (NJ),
    .DEPTH       (DEPTH),
    .ADDR_W      (32),
    .ADDR_BASE   (32'h0000_0000),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .found          (found),
    .sel_data       (sel_data),
    .sel_address    (sel_address),
    .mask           (mask),
    .free           (free),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .fifo_level     (fifo_level),
    .frame_done     (frame_done),
    .pixel_count    (pixel_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so the negedge sees what the next
  // posedge will sample.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt   = fd_cnt + 1;
      fd_at    = wr_log.size();
      pc_at_fd = pixel_count;
    end
    if (avm_write && !avm_waitrequest) wr_log.push_back({avm_address, avm_writedata});
    if (free != '0) free_log.push_back(free);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    found       = 1'b0;
    mask        = '0;
    sel_address = '1;
    sel_data    = '1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    avm_waitrequest = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic capture(input logic [15:0] m, input logic [31:0] a, input logic [31:0] d);
    found       = 1'b1;
    mask        = m;
    sel_address = a;
    sel_data    = d;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    avm_waitrequest = 1'b0;
    repeat (2) step();
    checks++;
    if ({free, avm_address, avm_write, avm_writedata, avm_byteenable, fifo_level, frame_done, pixel_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: free=%h addr=%h wr=%b data=%h be=%h lvl=%0d fd=%b pc=%0d, required all zero",
               free, avm_address, avm_write, avm_writedata, avm_byteenable, fifo_level, frame_done, pixel_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({free, avm_address, avm_write, avm_writedata, avm_byteenable, fifo_level, frame_done, pixel_count} !== '0) begin
        failures++;
        $display("FAIL idle_outputs cycle %0d: free=%h wr=%b lvl=%0d pc=%0d, required all zero",
                 i, free, avm_write, fifo_level, pixel_count);
      end
    end
  endtask

  task automatic test_single();
    int w0, f0;
    reset_dut();
    w0 = wr_log.size();
    f0 = free_log.size();
    found = 1'b1; mask = 16'h0004; sel_address = 32'd5; sel_data = 32'hDEADBEEF;
    step();
    checks++;
    if (free !== 16'h0004 || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL single_capture: free=%h lvl=%0d, required free=0004 lvl=1", free, fifo_level);
    end
    step();
    checks++;
    if (free !== 16'h0000 || avm_write !== 1'b1 || avm_address !== 32'h14 ||
        avm_writedata !== 32'hDEADBEEF || avm_byteenable !== 4'hF) begin
      failures++;
      $display("FAIL single_present: free=%h wr=%b addr=%h data=%h be=%h, required 0000 1 14 DEADBEEF F",
               free, avm_write, avm_address, avm_writedata, avm_byteenable);
    end
    step();
    checks++;
    if (avm_write !== 1'b0 || fifo_level !== 4'd0 || pixel_count !== 32'd1) begin
      failures++;
      $display("FAIL single_done: wr=%b lvl=%0d pc=%0d, required 0 0 1", avm_write, fifo_level, pixel_count);
    end
    idle_inputs();
    repeat (4) step();
    checks++;
    if (wr_log.size() - w0 !== 1 || free_log.size() - f0 !== 1) begin
      failures++;
      $display("FAIL single_counts: writes=%0d frees=%0d, required 1 1", wr_log.size() - w0, free_log.size() - f0);
    end else begin
      checks++;
      if (wr_log[w0] !== {32'h14, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL single_write: got %h, required %h", wr_log[w0], {32'h14, 32'hDEADBEEF});
      end
    end
  endtask

  task automatic test_stall();
    int w0;
    reset_dut();
    w0 = wr_log.size();
    avm_waitrequest = 1'b1;
    capture(16'h0001, 32'd10, 32'hAAAA_0001);
    capture(16'h0002, 32'd11, 32'hBBBB_0002);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_address !== 32'h28 || avm_writedata !== 32'hAAAA_0001 || fifo_level !== 4'd2) begin
        failures++;
        $display("FAIL stall_hold cycle %0d: wr=%b addr=%h data=%h lvl=%0d, required 1 28 AAAA0001 2",
                 i, avm_write, avm_address, avm_writedata, fifo_level);
      end
      if (i < 4) step();
    end
    avm_waitrequest = 1'b0;
    step();
    checks++;
    if (avm_write !== 1'b1 || avm_address !== 32'h2C || avm_writedata !== 32'hBBBB_0002 || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL stall_second: wr=%b addr=%h data=%h lvl=%0d, required 1 2C BBBB0002 1",
               avm_write, avm_address, avm_writedata, fifo_level);
    end
    step();
    checks++;
    if (avm_write !== 1'b0 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL stall_drained: wr=%b lvl=%0d, required 0 0", avm_write, fifo_level);
    end
    checks++;
    if (wr_log.size() - w0 !== 2 || wr_log[w0] !== {32'h28, 32'hAAAA_0001} || wr_log[w0+1] !== {32'h2C, 32'hBBBB_0002}) begin
      failures++;
      $display("FAIL stall_order: count=%0d, required 2 writes 28/AAAA0001 then 2C/BBBB0002", wr_log.size() - w0);
    end
  endtask

  task automatic test_full();
    int w0, f0;
    reset_dut();
    w0 = wr_log.size();
    f0 = free_log.size();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) capture(16'(1 << i), 32'(100 + i), 32'hC000_0000 + 32'(i));
    checks++;
    if (fifo_level !== 4'd8) begin
      failures++;
      $display("FAIL full_level: lvl=%0d, required 8", fifo_level);
    end
    found = 1'b1; mask = 16'h0100; sel_address = 32'd108; sel_data = 32'hC000_0008;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (free !== 16'h0000 || fifo_level !== 4'd8) begin
        failures++;
        $display("FAIL full_block cycle %0d: free=%h lvl=%0d, required 0000 8", i, free, fifo_level);
      end
    end
    avm_waitrequest = 1'b0;
    step();
    checks++;
    if (free !== 16'h0000 || fifo_level !== 4'd7) begin
      failures++;
      $display("FAIL full_pop_no_push: free=%h lvl=%0d, required 0000 7", free, fifo_level);
    end
    step();
    checks++;
    if (free !== 16'h0100 || fifo_level !== 4'd7) begin
      failures++;
      $display("FAIL full_push_pop: free=%h lvl=%0d, required 0100 7", free, fifo_level);
    end
    idle_inputs();
    repeat (12) step();
    checks++;
    if (wr_log.size() - w0 !== 9 || free_log.size() - f0 !== 9 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL full_counts: writes=%0d frees=%0d lvl=%0d, required 9 9 0",
               wr_log.size() - w0, free_log.size() - f0, fifo_level);
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (wr_log[w0+i] !== {32'((100 + i) * 4), 32'hC000_0000 + 32'(i)}) begin
          failures++;
          $display("FAIL full_order %0d: got %h, required %h", i, wr_log[w0+i],
                   {32'((100 + i) * 4), 32'hC000_0000 + 32'(i)});
        end
      end
    end
  endtask

  task automatic test_hold_change();
    int w0, f0;
    reset_dut();
    w0 = wr_log.size();
    f0 = free_log.size();
    found = 1'b1; mask = 16'h0001; sel_address = 32'd20; sel_data = 32'h1111_1111;
    step();
    checks++;
    if (free !== 16'h0001) begin
      failures++;
      $display("FAIL hold_first: free=%h, required 0001", free);
    end
    mask = 16'h0002; sel_address = 32'd21; sel_data = 32'h2222_2222;
    step();
    checks++;
    if (free !== 16'h0000) begin
      failures++;
      $display("FAIL hold_exit: free=%h, required 0000", free);
    end
    step();
    checks++;
    if (free !== 16'h0002) begin
      failures++;
      $display("FAIL hold_second: free=%h, required 0002", free);
    end
    step();
    checks++;
    if (free !== 16'h0000) begin
      failures++;
      $display("FAIL hold_no_repeat: free=%h, required 0000", free);
    end
    idle_inputs();
    repeat (5) step();
    checks++;
    if (free_log.size() - f0 !== 2 || free_log[f0] !== 16'h0001 || free_log[f0+1] !== 16'h0002) begin
      failures++;
      $display("FAIL hold_frees: count=%0d, required 2 pulses 0001 then 0002", free_log.size() - f0);
    end
    checks++;
    if (wr_log.size() - w0 !== 2 || wr_log[w0] !== {32'h50, 32'h1111_1111} || wr_log[w0+1] !== {32'h54, 32'h2222_2222}) begin
      failures++;
      $display("FAIL hold_writes: count=%0d, required 2 writes 50/11111111 then 54/22222222", wr_log.size() - w0);
    end
  endtask

  task automatic test_frame();
    int w0, fd0;
    reset_dut();
    w0  = wr_log.size();
    fd0 = fd_cnt;
    for (int i = 0; i < 5; i++) capture(16'(1 << i), 32'(200 + i), 32'hF000_0000 + 32'(i));
    repeat (4) step();
    checks++;
    if (wr_log.size() - w0 !== 5) begin
      failures++;
      $display("FAIL frame_writes: got %0d, required 5", wr_log.size() - w0);
    end
    checks++;
    if (fd_cnt - fd0 !== 1 || fd_at - w0 !== 4) begin
      failures++;
      $display("FAIL frame_done_pulse: pulses=%0d after_write=%0d, required 1 pulse after write 4",
               fd_cnt - fd0, fd_at - w0);
    end
    checks++;
    if (pc_at_fd !== 32'd0) begin
      failures++;
      $display("FAIL frame_wrap_count: pc=%0d at frame_done, required 0", pc_at_fd);
    end
    checks++;
    if (pixel_count !== 32'd1) begin
      failures++;
      $display("FAIL frame_after_fifth: pc=%0d, required 1", pixel_count);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    avm_waitrequest = 1'b1;
    capture(16'h0001, 32'd1, 32'h0000_0101);
    capture(16'h0002, 32'd2, 32'h0000_0202);
    capture(16'h0004, 32'd3, 32'h0000_0303);
    checks++;
    if (fifo_level !== 4'd3 || avm_write !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_setup: lvl=%0d wr=%b, required 3 1", fifo_level, avm_write);
    end
    rst = 1'b1;
    found = 1'b1; mask = 16'h0008; sel_address = 32'd4; sel_data = 32'h0000_0404;
    step();
    checks++;
    if (avm_write !== 1'b0 || fifo_level !== 4'd0 || free !== 16'h0000 ||
        avm_address !== 32'h0 || avm_byteenable !== 4'h0 || pixel_count !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_abort: wr=%b lvl=%0d free=%h addr=%h be=%h pc=%0d, required all zero",
               avm_write, fifo_level, free, avm_address, avm_byteenable, pixel_count);
    end
    rst = 1'b0;
    idle_inputs();
    avm_waitrequest = 1'b0;
    repeat (2) step();
    checks++;
    if (avm_write !== 1'b0 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL rstmid_after: wr=%b lvl=%0d, required 0 0", avm_write, fifo_level);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    avm_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_full();
    test_hold_change();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
